// File: rtl/ibuf_pkg.sv
// Shared types and width helpers for the skewed systolic input buffer.
//   ibuf_state_e : controller state (idle / streaming)
//   clog2_min1   : $clog2 clamped to a minimum of 1 bit
//   cw_of        : column-select width for N columns
//   cntw_of      : per-column occupancy counter width for DEPTH words
package ibuf_pkg;

  typedef enum logic {
    IBUF_IDLE = 1'b0,
    IBUF_RUN  = 1'b1
  } ibuf_state_e;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned cw_of(input int unsigned n);
    return clog2_min1(n);
  endfunction

  function automatic int unsigned cntw_of(input int unsigned depth);
    return clog2_min1(depth + 1);
  endfunction

endpackage

// File: rtl/ibuffer_lane.sv
// One column of the skewed input buffer: a DEPTH-word queue plus an element
// sequencer that walks the head word MSB element first, one element per cycle.
//   clk, rst_n  : clock, synchronous active-low reset
//   wr_en/wdata : push one N*DW word (caller guarantees not_full)
//   go          : start streaming the head word; first element appears next cycle
//   elem/valid  : registered element output, elem is 0 when not valid
//   not_empty   : at least one word queued
//   not_full    : room for another word
module ibuffer_lane
  import ibuf_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 2
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [N*DW-1:0] wdata,
  input  logic            go,
  output logic [DW-1:0]   elem,
  output logic            valid,
  output logic            not_empty,
  output logic            not_full
);

  localparam int unsigned WW   = N * DW;
  localparam int unsigned PW   = clog2_min1(DEPTH);
  localparam int unsigned IW   = clog2_min1(N);
  localparam int unsigned CNTW = cntw_of(DEPTH);

  logic [WW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic [IW-1:0]   idx;
  logic [WW-1:0]   head;
  logic            pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Element k sits at the MSB end for k=0.
  function automatic logic [DW-1:0] elem_at(input logic [WW-1:0] word, input logic [IW-1:0] k);
    int unsigned ki;
    ki = 32'(k);
    return word[(N - 1 - ki) * DW +: DW];
  endfunction

  assign head      = mem[rd_ptr];
  assign pop       = valid && (idx == IW'(N - 1));
  assign not_empty = (count != '0);
  assign not_full  = (count < CNTW'(DEPTH));

  // Data storage; only the wr_ptr slot is written, so the streaming head is stable.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Queue bookkeeping and element sequencer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      idx    <= '0;
      valid  <= 1'b0;
      elem   <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase

      if (go) begin
        valid <= 1'b1;
        idx   <= '0;
        elem  <= elem_at(head, '0);
      end else if (pop) begin
        valid <= 1'b0;
        idx   <= '0;
        elem  <= '0;
      end else if (valid) begin
        idx   <= idx + IW'(1);
        elem  <= elem_at(head, idx + IW'(1));
      end
    end
  end

endmodule

// File: rtl/ibuffer_skew_n.sv
// N-column input buffer for the west edge of an N x N systolic MAC array.
// Words are loaded per column; START_CALC streams every column's head word with
// column c delayed c cycles behind column 0.
//   CLK, RSTN          : clock, synchronous active-low reset
//   LOAD_EN/ICOL/IWORD : load request; accepted when LOAD_RDY (comb) is high
//   START_CALC         : request one skewed stream (needs every column non-empty)
//   BUSY, DONE         : registered run status / end-of-stream pulse
//   IROW_o, ICOL_VALID : registered per-column elements and valids
//   ODST_i, ODST_o     : destination tag, delayed one cycle
module ibuffer_skew_n
  import ibuf_pkg::*;
#(
  parameter  int unsigned N     = 4,
  parameter  int unsigned DW    = 8,
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned TAG_W = 4,
  localparam int unsigned CW    = cw_of(N)
)(
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              LOAD_EN,
  input  logic [CW-1:0]     ICOL,
  input  logic [N*DW-1:0]   IWORD,
  output logic              LOAD_RDY,
  input  logic              START_CALC,
  output logic              BUSY,
  output logic              DONE,
  output logic [N*DW-1:0]   IROW_o,
  output logic [N-1:0]      ICOL_VALID,
  input  logic [TAG_W-1:0]  ODST_i,
  output logic [TAG_W-1:0]  ODST_o
);

  localparam int unsigned TW  = clog2_min1(2 * N);
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned NFW = 1 << CW;

  ibuf_state_e   state, state_nx;
  logic [TW-1:0] t, t_nx;
  logic          done_nx;
  logic [N-1:0]  go;
  logic [N-1:0]  wr_sel;
  logic [N-1:0]  not_empty;
  logic [N-1:0]  not_full;
  logic [NFW-1:0] nf_pad;
  logic          in_range;

  // Column decode; padding keeps the lookup in range for any ICOL value.
  assign in_range = ({1'b0, ICOL} < CW1'(N));
  assign nf_pad   = NFW'(not_full);
  assign LOAD_RDY = in_range && nf_pad[ICOL];

  // Next-state logic. t counts cycles spent in RUN; lane c>0 starts when t==c-1,
  // lane 0 starts on the accepting edge itself.
  always_comb begin
    state_nx = state;
    t_nx     = t;
    done_nx  = 1'b0;
    go       = '0;
    case (state)
      IBUF_IDLE: begin
        if (START_CALC && (&not_empty)) begin
          state_nx = IBUF_RUN;
          t_nx     = '0;
          go[0]    = 1'b1;
        end
      end
      IBUF_RUN: begin
        for (int unsigned c = 1; c < N; c++) begin
          if (t == TW'(c - 1)) go[c] = 1'b1;
        end
        // Last element of column N-1 is on the outputs while t == 2N-2.
        if (t == TW'(2 * N - 2)) begin
          state_nx = IBUF_IDLE;
          t_nx     = '0;
          done_nx  = 1'b1;
        end else begin
          t_nx = t + TW'(1);
        end
      end
      default: state_nx = IBUF_IDLE;
    endcase
  end

  // State, status and tag registers.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state  <= IBUF_IDLE;
      t      <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      ODST_o <= '0;
    end else begin
      state  <= state_nx;
      t      <= t_nx;
      BUSY   <= (state_nx == IBUF_RUN);
      DONE   <= done_nx;
      ODST_o <= ODST_i;
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_lane
    assign wr_sel[c] = LOAD_EN && LOAD_RDY && (ICOL == CW'(c));

    ibuffer_lane #(
      .N     (N),
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk       (CLK),
      .rst_n     (RSTN),
      .wr_en     (wr_sel[c]),
      .wdata     (IWORD),
      .go        (go[c]),
      .elem      (IROW_o[(N-1-c)*DW +: DW]),
      .valid     (ICOL_VALID[c]),
      .not_empty (not_empty[c]),
      .not_full  (not_full[c])
    );
  end

endmodule

// File: tb/tb_ibuffer_skew_n.sv
// Directed bench for ibuffer_skew_n: main N=4/DW=8 instance plus N=2 and N=8
// (DW=16) instances for the parameter sweep. All share clock, reset and tag input.
module tb_ibuffer_skew_n;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shared
  logic       rstn   = 1'b0;
  logic [3:0] odst_i = '0;

  // Main instance
  logic        load_en = 1'b0;
  logic [1:0]  icol    = '0;
  logic [31:0] iword   = '0;
  logic        start   = 1'b0;
  logic        load_rdy, busy, done;
  logic [31:0] irow;
  logic [3:0]  valid, odst_o;

  // N=2 instance
  logic        load_en2 = 1'b0;
  logic [0:0]  icol2    = '0;
  logic [31:0] iword2   = '0;
  logic        start2   = 1'b0;
  logic        rdy2, busy2, done2;
  logic [31:0] irow2;
  logic [1:0]  valid2;
  logic [3:0]  odst_o2;

  // N=8 instance
  logic         load_en8 = 1'b0;
  logic [2:0]   icol8    = '0;
  logic [127:0] iword8   = '0;
  logic         start8   = 1'b0;
  logic         rdy8, busy8, done8;
  logic [127:0] irow8;
  logic [7:0]   valid8;
  logic [3:0]   odst_o8;

  ibuffer_skew_n #(.N(4), .DW(8), .DEPTH(2), .TAG_W(4)) dut (
    .CLK(clk), .RSTN(rstn), .LOAD_EN(load_en), .ICOL(icol), .IWORD(iword),
    .LOAD_RDY(load_rdy), .START_CALC(start), .BUSY(busy), .DONE(done),
    .IROW_o(irow), .ICOL_VALID(valid), .ODST_i(odst_i), .ODST_o(odst_o)
  );

  ibuffer_skew_n #(.N(2), .DW(16), .DEPTH(2), .TAG_W(4)) dut2 (
    .CLK(clk), .RSTN(rstn), .LOAD_EN(load_en2), .ICOL(icol2), .IWORD(iword2),
    .LOAD_RDY(rdy2), .START_CALC(start2), .BUSY(busy2), .DONE(done2),
    .IROW_o(irow2), .ICOL_VALID(valid2), .ODST_i(odst_i), .ODST_o(odst_o2)
  );

  ibuffer_skew_n #(.N(8), .DW(16), .DEPTH(2), .TAG_W(4)) dut8 (
    .CLK(clk), .RSTN(rstn), .LOAD_EN(load_en8), .ICOL(icol8), .IWORD(iword8),
    .LOAD_RDY(rdy8), .START_CALC(start8), .BUSY(busy8), .DONE(done8),
    .IROW_o(irow8), .ICOL_VALID(valid8), .ODST_i(odst_i), .ODST_o(odst_o8)
  );

  logic [31:0] wv [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge. The tag path is
  // checked on every edge against the value driven during the previous cycle.
  task automatic tick();
    logic       r;
    logic [3:0] prev;
    r    = rstn;
    prev = odst_i;
    @(posedge clk);
    #1;
    check("odst4", 64'(odst_o),  r ? 64'(prev) : 64'(0));
    check("odst2", 64'(odst_o2), r ? 64'(prev) : 64'(0));
    check("odst8", 64'(odst_o8), r ? 64'(prev) : 64'(0));
    odst_i = 4'($urandom);
  endtask

  task automatic load(input int c, input logic [31:0] w);
    icol    = 2'(c);
    iword   = w;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  task automatic load_all();
    for (int c = 0; c < N; c++) load(c, wv[c]);
  endtask

  // Start a stream and check every cycle against wv. Optionally drive a load
  // during cycle inj_j (relative to the START cycle).
  task automatic run_stream(input string name, input int inj_j, input int inj_col,
                            input logic [31:0] inj_word);
    logic [3:0]  ev;
    logic [31:0] er;
    int          k;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 2 * N + 1; j++) begin
      ev = '0;
      er = '0;
      for (int c = 0; c < N; c++) begin
        k = j - 1 - c;
        if (k >= 0 && k < N) begin
          ev[c] = 1'b1;
          er[(N-1-c)*DW +: DW] = wv[c][(N-1-k)*DW +: DW];
        end
      end
      check($sformatf("%s valid j%0d", name, j), 64'(valid), 64'(ev));
      check($sformatf("%s irow j%0d", name, j), 64'(irow), 64'(er));
      check($sformatf("%s busy j%0d", name, j), 64'(busy), 64'(j <= 2 * N - 1));
      check($sformatf("%s done j%0d", name, j), 64'(done), 64'(j == 2 * N));
      if (j == inj_j) begin
        icol    = 2'(inj_col);
        iword   = inj_word;
        load_en = 1'b1;
        #1;
        check($sformatf("%s inj_rdy", name), 64'(load_rdy), 64'(1));
      end else begin
        load_en = 1'b0;
      end
      tick();
    end
    load_en = 1'b0;
  endtask

  function automatic logic [127:0] mk8(input int c);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[(7-k)*16 +: 16] = 16'(c * 256 + k);
    return w;
  endfunction

  function automatic logic [31:0] mk2(input int c);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 2; k++) w[(1-k)*16 +: 16] = 16'(c * 256 + k);
    return w;
  endfunction

  initial begin
    logic [15:0] ee;
    int          k;

    // Reset state
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    #1;
    check("rst busy",  64'(busy),  64'(0));
    check("rst done",  64'(done),  64'(0));
    check("rst valid", 64'(valid), 64'(0));
    check("rst irow",  64'(irow),  64'(0));
    check("rst rdy",   64'(load_rdy), 64'(1));

    // 1: basic skewed stream
    wv[0] = 32'h03020100; wv[1] = 32'h13121110;
    wv[2] = 32'h23222120; wv[3] = 32'h33323130;
    load_all();
    run_stream("t1", -1, 0, '0);

    // 2: START ignored with col3 empty
    wv[0] = 32'hA3A2A1A0; wv[1] = 32'hB3B2B1B0;
    wv[2] = 32'hC3C2C1C0; wv[3] = 32'hD3D2D1D0;
    for (int c = 0; c < 3; c++) load(c, wv[c]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("t2 valid %0d", j), 64'(valid), 64'(0));
      check($sformatf("t2 busy %0d", j),  64'(busy),  64'(0));
      tick();
    end
    load(3, wv[3]);
    run_stream("t2", -1, 0, '0);

    // 3: col1 depth limit, third write dropped
    load(1, 32'h11111111);
    load(1, 32'h22222222);
    icol = 2'd1;
    #1;
    check("t3 full rdy", 64'(load_rdy), 64'(0));
    load(1, 32'h33333333);
    wv[0] = 32'h01020304; wv[1] = 32'h11111111;
    wv[2] = 32'h05060708; wv[3] = 32'h090A0B0C;
    load(0, wv[0]); load(2, wv[2]); load(3, wv[3]);
    run_stream("t3a", -1, 0, '0);
    icol = 2'd1;
    #1;
    check("t3 rdy after run", 64'(load_rdy), 64'(1));
    wv[0] = 32'h40414243; wv[1] = 32'h22222222;
    wv[2] = 32'h50515253; wv[3] = 32'h60616263;
    load(0, wv[0]); load(2, wv[2]); load(3, wv[3]);
    run_stream("t3b", -1, 0, '0);

    // 4: load col2 on its pop cycle
    wv[0] = 32'h70717273; wv[1] = 32'h74757677;
    wv[2] = 32'h78797A7B; wv[3] = 32'h7C7D7E7F;
    load_all();
    run_stream("t4a", 6, 2, 32'hE0E1E2E3);
    icol = 2'd2;
    #1;
    check("t4 rdy cnt1", 64'(load_rdy), 64'(1));
    load(2, 32'hF0F1F2F3);
    icol = 2'd2;
    #1;
    check("t4 rdy cnt2", 64'(load_rdy), 64'(0));
    wv[0] = 32'h80818283; wv[1] = 32'h84858687;
    wv[2] = 32'hE0E1E2E3; wv[3] = 32'h8C8D8E8F;
    load(0, wv[0]); load(1, wv[1]); load(3, wv[3]);
    run_stream("t4b", -1, 0, '0);

    // 5: reset mid-RUN
    load_all();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    tick();
    check("t5 valid", 64'(valid), 64'(0));
    check("t5 irow",  64'(irow),  64'(0));
    check("t5 busy",  64'(busy),  64'(0));
    check("t5 done",  64'(done),  64'(0));
    rstn = 1'b1;
    for (int c = 0; c < N; c++) begin
      icol = 2'(c);
      #1;
      check($sformatf("t5 rdy c%0d", c), 64'(load_rdy), 64'(1));
    end
    for (int j = 0; j < 8; j++) begin
      tick();
      check($sformatf("t5 nodone %0d", j), 64'(done), 64'(0));
      check($sformatf("t5 nobusy %0d", j), 64'(busy), 64'(0));
    end

    // 6: parameter sweep N=2 and N=8, DW=16
    for (int c = 0; c < 8; c++) begin
      icol8 = 3'(c); iword8 = mk8(c); load_en8 = 1'b1;
      if (c < 2) begin
        icol2 = 1'(c); iword2 = mk2(c); load_en2 = 1'b1;
      end else begin
        load_en2 = 1'b0;
      end
      #1;
      check($sformatf("t6 rdy8 c%0d", c), 64'(rdy8), 64'(1));
      if (c < 2) check($sformatf("t6 rdy2 c%0d", c), 64'(rdy2), 64'(1));
      tick();
    end
    load_en8 = 1'b0;
    load_en2 = 1'b0;
    start2 = 1'b1;
    start8 = 1'b1;
    tick();
    start2 = 1'b0;
    start8 = 1'b0;
    for (int j = 1; j <= 18; j++) begin
      for (int c = 0; c < 8; c++) begin
        k  = j - 1 - c;
        ee = (k >= 0 && k < 8) ? 16'(c * 256 + k) : 16'h0;
        check($sformatf("t6 v8 j%0d c%0d", j, c), 64'(valid8[c]), 64'(k >= 0 && k < 8));
        check($sformatf("t6 e8 j%0d c%0d", j, c), 64'(irow8[(7-c)*16 +: 16]), 64'(ee));
        if (c < 2) begin
          ee = (k >= 0 && k < 2) ? 16'(c * 256 + k) : 16'h0;
          check($sformatf("t6 v2 j%0d c%0d", j, c), 64'(valid2[c]), 64'(k >= 0 && k < 2));
          check($sformatf("t6 e2 j%0d c%0d", j, c), 64'(irow2[(1-c)*16 +: 16]), 64'(ee));
        end
      end
      check($sformatf("t6 done8 j%0d", j), 64'(done8), 64'(j == 16));
      check($sformatf("t6 busy8 j%0d", j), 64'(busy8), 64'(j <= 15));
      check($sformatf("t6 done2 j%0d", j), 64'(done2), 64'(j == 4));
      check($sformatf("t6 busy2 j%0d", j), 64'(busy2), 64'(j <= 3));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
